// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice:
//   - memory op codes driven on the memory WE pins
//   - arbiter FSM state type
//   - op-code classification helpers (store / legal)
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_SB  = 3'b011;

  // Burst counter width; holds values up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_SW) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
// Ports:
//   i_req     [1:0]  request vector (bit p = port p)
//   i_lastGnt        index of the port granted most recently
//   o_gnt     [1:0]  one-hot pick, zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_lastGnt,
  output logic [1:0] o_gnt
);

  // A lone requester always wins; on contention the port that did not
  // win last time goes first.
  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_lastGnt ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-cycle data memory between the core load/store port
// (port 0) and the loader/debug port (port 1). At most one access is issued
// per cycle, with round-robin fairness and a bounded lock/burst mechanism.
// Load data is registered and flagged with a one-cycle rvalid pulse.
//
// Optional build macro: DMEM_ARB_ALIGN_CHECK_EN
//   defined   -> misaligned word ops are rejected with an err pulse
//   undefined -> misaligned word ops pass through unchanged
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_i, lock_i    [1:0] per-port request and burst-lock hint
//   op0_i/op1_i      [2:0] per-port memory op code
//   addr0_i/addr1_i        per-port byte address
//   wdata0_i/wdata1_i      per-port store data
//   gnt_o            [1:0] one-hot combinational grant
//   rvalid_o         [1:0] read-data-valid pulse, cycle after a load
//   rdata_o                registered load data
//   err_o            [1:0] error pulse, cycle after a rejected op
//   mem_we_o/a_o/wd_o      memory control/address/write data
//   mem_rd_i               memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [1:0]        lock_i,
  input  logic [2:0]        op0_i,
  input  logic [2:0]        op1_i,
  input  logic [DATA_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        err_o,
  output logic [2:0]        mem_we_o,
  output logic [DATA_W-1:0] mem_a_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  logic              r_lastGnt;
  logic [CNT_W-1:0]  r_burstCnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_rrGnt;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_aligned;
  logic              w_accept;

  rr_arb2 u_rr (
    .i_req     (req_i),
    .i_lastGnt (r_lastGnt),
    .o_gnt     (w_rrGnt)
  );

  // Next-state logic. A port holding ownership keeps the grant while it
  // requests with lock set; the counter only advances when the other port
  // is actually waiting, so an uncontested burst never expires. Whenever a
  // port is granted through arbitration (fresh or by hand-off) and is
  // locking, it enters ownership with the grant it just received counted.
  always_comb begin
    logic owner;
    logic other;
    logic useRr;
    logic winner;

    w_gnt       = 2'b00;
    w_nextState = IDLE;
    w_nextCnt   = '0;
    useRr       = 1'b1;
    owner       = (r_state == OWN1);
    other       = ~owner;
    winner      = 1'b0;

    if ((r_state == OWN0) || (r_state == OWN1)) begin
      if (req_i[owner] && lock_i[owner]) begin
        useRr = 1'b0;
        if (req_i[other] && (r_burstCnt == CNT_W'(MAX_BURST))) begin
          w_gnt[other] = 1'b1;
          winner       = other;
          if (lock_i[other]) begin
            w_nextState = other ? OWN1 : OWN0;
            w_nextCnt   = CNT_W'(1);
          end
        end else begin
          w_gnt[owner] = 1'b1;
          w_nextState  = r_state;
          w_nextCnt    = req_i[other] ? r_burstCnt + CNT_W'(1) : r_burstCnt;
        end
      end
    end

    if (useRr && (w_rrGnt != 2'b00)) begin
      w_gnt  = w_rrGnt;
      winner = w_rrGnt[1];
      if (lock_i[winner]) begin
        w_nextState = winner ? OWN1 : OWN0;
        w_nextCnt   = CNT_W'(1);
      end
    end
  end

  // Issue path: mux the granted port onto the memory pins and decide
  // whether the op is actually performed or rejected.
  always_comb begin
    w_any   = (w_gnt != 2'b00);
    w_sel   = w_gnt[1];
    w_op    = w_sel ? op1_i    : op0_i;
    w_addr  = w_sel ? addr1_i  : addr0_i;
    w_wdata = w_sel ? wdata1_i : wdata0_i;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    w_aligned = !(((w_op == OP_LW) || (w_op == OP_SW)) && (w_addr[1:0] != 2'b00));
`else
    w_aligned = 1'b1;
`endif
    w_accept  = w_any && is_legal(w_op) && w_aligned;
  end

  // Reset forces the memory into a harmless read and suppresses grants.
  assign gnt_o    = rst_n ? w_gnt : 2'b00;
  assign mem_we_o = (rst_n && w_accept) ? w_op : 3'b000;
  assign mem_a_o  = w_any ? w_addr  : '0;
  assign mem_wd_o = w_any ? w_wdata : '0;

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lastGnt  <= 1'b1;
      r_burstCnt <= '0;
      r_rvalid   <= 2'b00;
      r_err      <= 2'b00;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_burstCnt <= w_nextCnt;
      r_rvalid   <= 2'b00;
      r_err      <= 2'b00;
      if (w_any) begin
        r_lastGnt <= w_gnt[1];
        if (!w_accept) begin
          r_err <= w_gnt;
        end else if (!is_store(w_op)) begin
          r_rvalid <= w_gnt;
          r_rdata  <= mem_rd_i;
        end
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter sharing the single-cycle data memory (async read, sync write, 3-bit op code on WE) between the core load/store port (port 0) and the program/debug loader port (port 1).
- Issues at most one access per cycle.
- Round-robin fairness, plus a bounded lock/burst mechanism.
- Returns registered read data with a one-cycle valid pulse.
- Sits between the core/loader and the data memory, owning the memory WE/A/WD pins.

Parameters:
DATA_W, 32, data and address width.
MAX_BURST, 4, max consecutive locked grants to one port while the other port is requesting (1..15).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_i  in  2  per-port access request (bit p = port p)
lock_i  in  2  per-port burst lock hint, sampled with req
op0_i, op1_i  in  3 each  memory op code: 000 lw, 010 lb, 110 lbu, 001 sw, 011 sb
addr0_i, addr1_i  in  DATA_W each  byte address
wdata0_i, wdata1_i  in  DATA_W each  store data
gnt_o  out  2  one-hot grant, combinational, same cycle as issue
rvalid_o  out  2  one-cycle read-data-valid pulse, cycle after a granted load
rdata_o  out  DATA_W  registered load data, shared by both ports
err_o  out  2  one-cycle error pulse (see Optional Feature)
mem_we_o  out  3  to memory WE
mem_a_o  out  DATA_W  to memory A
mem_wd_o  out  DATA_W  to memory WD
mem_rd_i  in  DATA_W  from memory RD

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, state=IDLE, last_gnt=1 (so port 0 wins first), burst_cnt=0.
- While rst_n=0, mem_we_o is forced to 000 (read, never a write).
- Idle memory drive: when no port is granted, mem_we_o=000, mem_a_o=0, mem_wd_o=0.
- Issue: the granted port's op/addr/wdata are muxed combinationally onto the mem_* pins in the grant cycle.
  - Stores commit at the next posedge.
  - Loads: mem_rd_i is captured into rdata_o at that posedge, and rvalid_o[p]=1 for exactly the next cycle.
  - rdata_o holds its value until the next load.
- Op legality: op codes 100, 101 and 111 are illegal.
  - They are granted and consume the cycle.
  - mem_we_o is driven as 000.
  - No rvalid is produced.
  - err_o[p] pulses in the next cycle (err_o is always present).
- FSM states: IDLE, OWN0, OWN1.
  - IDLE, single requester: grant it.
  - IDLE, both requesting: grant ~last_gnt.
  - IDLE, granted port also has lock_i set: next state is OWNp and burst_cnt=1.
  - OWNp with req_i[p]&lock_i[p]: grant p again.
    - If the other port is requesting, burst_cnt increments.
    - If burst_cnt==MAX_BURST and the other port is requesting, the grant goes to the other port, burst_cnt=0, and next state is IDLE (or OWN of the other port if it is locking).
  - OWNp when req_i[p]=0 or lock_i[p]=0: ownership is released the same cycle and arbitration proceeds as in IDLE.
  - burst_cnt does not count while the other port is idle, so an uncontested burst is unbounded.
- last_gnt updates on every grant.
- A grant is given only when the corresponding req_i bit is high; gnt_o is one-hot or zero.
- Requesters must hold op/addr/wdata stable while req is high and not granted.
- Reset mid-burst: state returns to IDLE and no pending rvalid/err is delivered after reset release.

Optional Feature:
Macro DMEM_ARB_ALIGN_CHECK_EN.
- Defined: word ops (000, 001) with addr[1:0]!=0 are rejected.
  - They are granted, but mem_we_o is driven as 000 and nothing is written.
  - err_o[p] pulses in the next cycle and no rvalid is produced.
- Undefined: misaligned word ops are forwarded unchanged; the memory aligns the address down.

Decomposition:
Shared package dmem_pkg holds:
- op-code localparams: OP_LW=3'b000, OP_LB=3'b010, OP_LBU=3'b110, OP_SW=3'b001, OP_SB=3'b011;
- the arb_state_t enum {IDLE, OWN0, OWN1};
- a helper function is_store(op) and is_legal(op).

One natural sub-module is rr_arb2: a combinational 2-way round-robin pick from req and last_gnt. The FSM, burst counter and response registers stay in dmem_arbiter.

Test Plan:
- Reset, then req_i=11 with both lw -> cycle 1 gnt_o=01, cycle 2 gnt_o=10; rvalid_o=01 then 10 with the respective memory words.
- Port 0 sw addr 0x10 data 0xDEADBEEF, then port 1 lw 0x10 -> rdata_o=0xDEADBEEF, rvalid_o=10.
- Port 0 lock_i=1 and req held, port 1 requesting, MAX_BURST=4 -> four grants to port 0, fifth to port 1, then back to port 0.
- Port 1 op=3'b101 -> gnt_o=10, mem_we_o=000, err_o=10 next cycle, no rvalid, memory unchanged.
- DMEM_ARB_ALIGN_CHECK_EN defined, port 0 sw addr 0x13 -> err_o=01 and memory unchanged; undefined -> bytes 0x10..0x13 are written.
- rst_n pulled low during an OWN0 burst, with a load in flight -> rvalid_o=0 immediately; after release, gnt_o follows IDLE rules and port 0 is granted first.
